rv32_prefetch_queue: RTL

//  Parametrised instruction prefetcher between rv32 fetch stage and instruction memory bus.

---
 rtl/rv32_prefetch_pkg.sv | 19 +
 rtl/rv32_sync_fifo.sv | 54 +++++
 rtl/rv32_prefetch_queue.sv | 108 ++++++++++
 3 files changed

// File: rtl/rv32_prefetch_pkg.sv
// Shared types and constants for the rv32 instruction prefetch queue.
// Queue entries hold up to 32-bit addresses and 32-bit instruction words.
package rv32_prefetch_pkg;

  localparam int unsigned PF_ADDR_WIDTH = 32;
  localparam int unsigned PF_DATA_WIDTH = 32;
  localparam int unsigned PF_STEP       = 4;

  typedef struct packed {
    logic [PF_ADDR_WIDTH-1:0] addr;
    logic [PF_DATA_WIDTH-1:0] data;
  } pf_entry_t;

  // Occupancy counter needs one extra bit to represent a full queue.
  function automatic int unsigned pf_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rv32_sync_fifo.sv
// Power-of-two depth synchronous FIFO with head peek and synchronous clear.
// Push while full and pop while empty are ignored.
module rv32_sync_fifo
  import rv32_prefetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = pf_cnt_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_ || i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/rv32_prefetch_queue.sv
// Sequential instruction prefetcher between the rv32 fetch stage and the
// instruction bus; redirects on non-sequential fetch or flush.
module rv32_prefetch_queue
  import rv32_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic [ADDR_WIDTH-1:0] core_address_in,
  input  logic                  core_read_in,
  output logic [DATA_WIDTH-1:0] core_read_value_out,
  output logic                  core_ready_out,
  input  logic                  flush_in,
  output logic [ADDR_WIDTH-1:0] mem_address_out,
  output logic                  mem_read_out,
  input  logic [DATA_WIDTH-1:0] mem_read_value_in,
  input  logic                  mem_ready_in,
  output logic [31:0]           hit_count_out,
  output logic [31:0]           miss_count_out
);

  logic [ADDR_WIDTH-1:0] r_pf_addr;
  logic [31:0]           r_hit_count;
  logic [31:0]           r_miss_count;

  pf_entry_t             w_head;
  pf_entry_t             w_push_entry;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [ADDR_WIDTH-1:0] w_expected;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_hit;
  logic                  w_redirect;
  logic                  w_mem_fire;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_clear;

  assign w_head_addr  = ADDR_WIDTH'(w_head.addr);
  assign w_head_data  = DATA_WIDTH'(w_head.data);
  assign w_push_entry = '{addr: PF_ADDR_WIDTH'(r_pf_addr), data: PF_DATA_WIDTH'(mem_read_value_in)};

  rv32_sync_fifo #(
    .WIDTH ($bits(pf_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_  (reset_),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_hit),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Hit/redirect decode, bus request and core response; all quiet in reset.
  always_comb begin
    w_expected          = w_empty ? r_pf_addr : w_head_addr;
    w_hit               = 1'b0;
    w_redirect          = 1'b0;
    w_mem_fire          = 1'b0;
    w_bypass            = 1'b0;
    w_push              = 1'b0;
    w_clear             = 1'b0;
    mem_read_out        = 1'b0;
    core_ready_out      = 1'b0;
    core_read_value_out = '0;
    if (reset_) begin
      w_hit          = core_read_in && !flush_in && !w_empty && (w_head_addr == core_address_in);
      w_redirect     = core_read_in && !flush_in && (core_address_in != w_expected);
      mem_read_out   = !w_full && !w_redirect && !flush_in;
      w_mem_fire     = mem_read_out && mem_ready_in;
      w_bypass       = (BYPASS != 0) && w_empty && core_read_in &&
                       (core_address_in == r_pf_addr) && w_mem_fire;
      core_ready_out = w_hit || w_bypass;
      if (w_hit)         core_read_value_out = w_head_data;
      else if (w_bypass) core_read_value_out = mem_read_value_in;
      w_push         = w_mem_fire && !w_bypass;
      w_clear        = flush_in || w_redirect;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_pf_addr    <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (flush_in)        r_pf_addr <= core_read_in ? core_address_in : w_expected;
      else if (w_redirect) r_pf_addr <= core_address_in;
      else if (w_mem_fire) r_pf_addr <= r_pf_addr + ADDR_WIDTH'(PF_STEP);
      if (w_hit && (r_hit_count != 32'hFFFF_FFFF))       r_hit_count  <= r_hit_count + 32'd1;
      if (w_redirect && (r_miss_count != 32'hFFFF_FFFF)) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign mem_address_out = r_pf_addr;
  assign hit_count_out   = r_hit_count;
  assign miss_count_out  = r_miss_count;

endmodule
